chess_timer_ctrl: RTL

Two-player chess clock controller. It keeps each player's remaining time as 4-digit BCD (MM:SS) and counts down the active player once per second. It switches the active player on move completion and presents the active player's time as four BCD nibbles. The top level feeds these nibbles into four SevenSegmentDisplay decoder instances; nibble value 4'hF is the blank code, which the decoder renders as all segments off.

---
 rtl/chess_pkg.sv | 33 +++
 rtl/bcd_time_dec.sv | 34 +++
 rtl/chess_timer_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared types and constants for the chess clock controller: FSM states, player
// encoding, the display blank code and the MM:SS BCD time record.
package chess_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [3:0] BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } time_t;

  function automatic time_t make_time(input int mins, input int secs);
    time_t t;
    t.min_tens = 4'((mins / 10) % 10);
    t.min_ones = 4'(mins % 10);
    t.sec_tens = 4'((secs / 10) % 10);
    t.sec_ones = 4'(secs % 10);
    return t;
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational MM:SS decrement by one second with BCD borrow, plus a flag
// that the decremented time is 00:00.
module bcd_time_dec
  import chess_pkg::*;
(
  input  time_t cur,
  output time_t nxt,
  output logic  zero
);

  // Borrow ripples from seconds-ones up to minutes-tens.
  always_comb begin
    nxt = cur;
    if (cur.sec_ones != 4'd0) begin
      nxt.sec_ones = cur.sec_ones - 4'd1;
    end else begin
      nxt.sec_ones = 4'd9;
      if (cur.sec_tens != 4'd0) begin
        nxt.sec_tens = cur.sec_tens - 4'd1;
      end else begin
        nxt.sec_tens = 4'd5;
        if (cur.min_ones != 4'd0) begin
          nxt.min_ones = cur.min_ones - 4'd1;
        end else begin
          nxt.min_ones = 4'd9;
          nxt.min_tens = cur.min_tens - 4'd1;
        end
      end
    end
  end

  assign zero = (nxt == 16'h0000);

endmodule

// File: rtl/chess_timer_ctrl.sv
// Two-player chess clock: per-player BCD countdown, move switching, pause,
// flag fall detection and the displayed digits of the active player.
module chess_timer_ctrl
  import chess_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int START_MIN = 10,
  parameter int START_SEC = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic        MoveDone,
  input  logic        Pause,
  output logic        ActivePlayer,
  output logic [15:0] Digits,
  output logic        LowTime,
  output logic        Timeout,
  output logic        Loser
);

  localparam int            CW         = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] LAST       = CW'(CLK_FREQ - 1);
  localparam logic [CW-1:0] HALF       = CW'(CLK_FREQ / 2);
  localparam time_t         START_TIME = make_time(START_MIN, START_SEC);

  state_t        state_r, state_s;
  time_t         white_r, white_s, black_r, black_s;
  logic          active_r, active_s;
  logic          timeout_r, timeout_s;
  logic          loser_r, loser_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
  time_t         cur_s, dec_s;
  logic          zero_s, tick_s;

  assign cur_s     = (active_r == BLACK) ? black_r : white_r;
  assign tick_s    = (cnt_r == LAST);
  assign cnt_inc_s = tick_s ? '0 : cnt_r + CW'(1);

  bcd_time_dec u_dec (
    .cur  (cur_s),
    .nxt  (dec_s),
    .zero (zero_s)
  );

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      white_r   <= START_TIME;
      black_r   <= START_TIME;
      active_r  <= WHITE;
      timeout_r <= 1'b0;
      loser_r   <= WHITE;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_s;
      white_r   <= white_s;
      black_r   <= black_s;
      active_r  <= active_s;
      timeout_r <= timeout_s;
      loser_r   <= loser_s;
      cnt_r     <= cnt_s;
    end
  end

  // Next-state logic: Start reload, countdown, move toggle and pause.
  always_comb begin
    state_s   = state_r;
    white_s   = white_r;
    black_s   = black_r;
    active_s  = active_r;
    timeout_s = timeout_r;
    loser_s   = loser_r;
    cnt_s     = cnt_r;
    if (Start && (state_r == IDLE || state_r == TIMEOUT)) begin
      state_s   = RUN;
      white_s   = START_TIME;
      black_s   = START_TIME;
      active_s  = WHITE;
      timeout_s = 1'b0;
      loser_s   = WHITE;
      cnt_s     = '0;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        RUN: begin
          cnt_s = cnt_inc_s;
          if (tick_s) begin
            if (active_r == BLACK) black_s = dec_s;
            else                   white_s = dec_s;
          end else begin
            white_s = white_r;
          end
          // A flag fall overrides both a coincident move and a pause request.
          if (tick_s && zero_s) begin
            state_s   = TIMEOUT;
            timeout_s = 1'b1;
            loser_s   = active_r;
          end else begin
            if (MoveDone) active_s = ~active_r;
            else          active_s = active_r;
            if (Pause)    state_s = PAUSED;
            else          state_s = RUN;
          end
        end
        PAUSED: begin
          if (!Pause) state_s = RUN;
          else        state_s = PAUSED;
        end
        TIMEOUT: cnt_s = cnt_inc_s;
        default: state_s = IDLE;
      endcase
    end
  end

  // Output decode straight from the registers.
  always_comb begin
    if (state_r == TIMEOUT) begin
      Digits = (cnt_r < HALF) ? 16'h0000 : {4{BLANK}};
    end else begin
      Digits = cur_s;
    end
    if (state_r != IDLE && cur_s.min_tens == 4'd0 && cur_s.min_ones == 4'd0 &&
        (cur_s.sec_tens == 4'd0 || (cur_s.sec_tens == 4'd1 && cur_s.sec_ones == 4'd0))) begin
      LowTime = 1'b1;
    end else begin
      LowTime = 1'b0;
    end
  end

  assign ActivePlayer = active_r;
  assign Timeout      = timeout_r;
  assign Loser        = loser_r;

endmodule
